// File: rtl/shift_piso_ctl.sv
// Parallel-in/serial-out shifter with load/shift control, bit counter, DONE/OVR pulses.
// SO is available the cycle after LOAD. A LOAD during a word is refused with OVR, except on the final strobe.

function automatic int shift_piso_ctl_cw(input int n);
  int w;
  w = 0;
  for (int v = n; v > 0; v = v >> 1) w++;
  return w;
endfunction

module shift_piso_ctl #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = shift_piso_ctl_cw(WIDTH)
) (
  input  logic             C,
  input  logic             RST_N,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             SHIFT_EN,
  input  logic             SI,
  output logic             SO,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVR,
  output logic [CW-1:0]    BITCNT
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt, w_shifted;
  logic [CW-1:0]    r_bitcnt, w_bitcnt_nxt;
  logic             r_done, r_ovr, w_done_nxt, w_ovr_nxt;
  logic             w_last;

  generate
    if (MSB_FIRST) begin : g_msb
      assign w_shifted = {r_shreg[WIDTH-2:0], SI};
    end else begin : g_lsb
      assign w_shifted = {SI, r_shreg[WIDTH-1:1]};
    end
  endgenerate

  assign w_last = SHIFT_EN && (r_bitcnt == CW'(1));

  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_bitcnt_nxt = r_bitcnt;
    w_done_nxt   = 1'b0;
    w_ovr_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (LOAD) begin
          w_shreg_nxt  = D;
          w_bitcnt_nxt = CW'(WIDTH);
          w_state_nxt  = SHIFT;
        end else if (SHIFT_EN) begin
          w_shreg_nxt = w_shifted;
        end
      end
      SHIFT: begin
        if (SHIFT_EN) begin
          w_shreg_nxt  = w_shifted;
          w_bitcnt_nxt = r_bitcnt - CW'(1);
        end
        // Final strobe: a coincident LOAD chains the next word with no gap.
        if (w_last) begin
          w_done_nxt = 1'b1;
          if (LOAD) begin
            w_shreg_nxt  = D;
            w_bitcnt_nxt = CW'(WIDTH);
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (LOAD) begin
          w_ovr_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge C) begin
    if (!RST_N) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_done   <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_done   <= w_done_nxt;
      r_ovr    <= w_ovr_nxt;
    end
  end

  assign SO     = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
  assign BUSY   = (r_state == SHIFT);
  assign DONE   = r_done;
  assign OVR    = r_ovr;
  assign BITCNT = r_bitcnt;

endmodule

// File: tb/tb_shift_piso_ctl.sv
// Bench for shift_piso_ctl: directed vector table, a spaced-strobe sequence on both bit orders,
// and random traffic against an output-order bit-list model.
module tb_shift_piso_ctl;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n, load, sen, si;
  logic [W-1:0]  d;
  logic          so_m, busy_m, done_m, ovr_m;
  logic          so_l, busy_l, done_l, ovr_l;
  logic [CW-1:0] cnt_m, cnt_l;

  always #5 clk = ~clk;

  shift_piso_ctl #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .C(clk), .RST_N(rst_n), .LOAD(load), .D(d), .SHIFT_EN(sen), .SI(si),
    .SO(so_m), .BUSY(busy_m), .DONE(done_m), .OVR(ovr_m), .BITCNT(cnt_m));

  shift_piso_ctl #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .C(clk), .RST_N(rst_n), .LOAD(load), .D(d), .SHIFT_EN(sen), .SI(si),
    .SO(so_l), .BUSY(busy_l), .DONE(done_l), .OVR(ovr_l), .BITCNT(cnt_l));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       r, l;
    logic [7:0] dd;
    logic       s, i;
    logic       eso, eb, ed, eo;
    int         ec;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic l, logic [7:0] dd, logic s, logic i,
                              logic eso, logic eb, logic ed, logic eo, int ec);
    vec_t v;
    v.r = r; v.l = l; v.dd = dd; v.s = s; v.i = i;
    v.eso = eso; v.eb = eb; v.ed = ed; v.eo = eo; v.ec = ec;
    return v;
  endfunction

  // Reference: each instance holds its word as a list in transmit order; ob[k][0] is on SO.
  bit ob[2][W];
  int rem;
  bit m_done, m_ovr;

  task automatic model_step();
    bit accept;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) for (int i = 0; i < W; i++) ob[k][i] = 1'b0;
      rem = 0; m_done = 1'b0; m_ovr = 1'b0;
    end else begin
      accept = load && (rem == 0 || (sen && rem == 1));
      m_done = sen && rem == 1;
      m_ovr  = load && !accept;
      if (accept) begin
        for (int i = 0; i < W; i++) begin
          ob[0][i] = d[W-1-i];
          ob[1][i] = d[i];
        end
        rem = W;
      end else if (sen) begin
        for (int k = 0; k < 2; k++) begin
          for (int i = 0; i < W-1; i++) ob[k][i] = ob[k][i+1];
          ob[k][W-1] = si;
        end
        if (rem > 0) rem--;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] em;
    rst_n = 1'b0; load = 1'b0; d = '0; sen = 1'b0; si = 1'b0;

    //           r  l  d      s  i   so b  dn o  cnt
    vq.push_back(mk(0, 1, 8'hFF, 0, 0,  0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 8'hFF, 0, 0,  0, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 8'h96, 0, 0,  1, 1, 0, 0, 8));
    vq.push_back(mk(1, 0, 8'h00, 1, 0,  0, 1, 0, 0, 7));
    vq.push_back(mk(1, 1, 8'h3C, 0, 0,  0, 1, 0, 1, 7));
    vq.push_back(mk(1, 0, 8'h00, 0, 0,  0, 1, 0, 0, 7));
    vq.push_back(mk(1, 0, 8'h00, 1, 0,  0, 1, 0, 0, 6));
    vq.push_back(mk(1, 0, 8'h00, 1, 0,  1, 1, 0, 0, 5));
    vq.push_back(mk(1, 0, 8'h00, 1, 0,  0, 1, 0, 0, 4));
    vq.push_back(mk(1, 0, 8'h00, 1, 0,  1, 1, 0, 0, 3));
    vq.push_back(mk(1, 0, 8'h00, 1, 0,  1, 1, 0, 0, 2));
    vq.push_back(mk(1, 0, 8'h00, 1, 0,  0, 1, 0, 0, 1));
    vq.push_back(mk(1, 1, 8'h3C, 1, 0,  0, 1, 1, 0, 8));
    vq.push_back(mk(1, 0, 8'h00, 0, 0,  0, 1, 0, 0, 8));
    vq.push_back(mk(1, 0, 8'h00, 1, 1,  0, 1, 0, 0, 7));
    vq.push_back(mk(1, 0, 8'h00, 1, 1,  1, 1, 0, 0, 6));
    vq.push_back(mk(1, 0, 8'h00, 1, 1,  1, 1, 0, 0, 5));
    vq.push_back(mk(1, 0, 8'h00, 1, 1,  1, 1, 0, 0, 4));
    vq.push_back(mk(1, 0, 8'h00, 1, 1,  1, 1, 0, 0, 3));
    vq.push_back(mk(1, 0, 8'h00, 1, 1,  0, 1, 0, 0, 2));
    vq.push_back(mk(1, 0, 8'h00, 1, 1,  0, 1, 0, 0, 1));
    vq.push_back(mk(1, 0, 8'h00, 1, 1,  1, 0, 1, 0, 0));
    vq.push_back(mk(1, 0, 8'h00, 1, 0,  1, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 8'h00, 0, 0,  1, 0, 0, 0, 0));
    vq.push_back(mk(1, 1, 8'hA5, 0, 0,  1, 1, 0, 0, 8));
    vq.push_back(mk(1, 0, 8'h00, 1, 0,  0, 1, 0, 0, 7));
    vq.push_back(mk(1, 0, 8'h00, 1, 0,  1, 1, 0, 0, 6));
    vq.push_back(mk(1, 0, 8'h00, 1, 0,  0, 1, 0, 0, 5));
    vq.push_back(mk(1, 0, 8'h00, 1, 0,  0, 1, 0, 0, 4));
    vq.push_back(mk(0, 0, 8'h00, 1, 0,  0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 8'h00, 0, 0,  0, 0, 0, 0, 0));

    foreach (vq[i]) begin
      rst_n = vq[i].r; load = vq[i].l; d = vq[i].dd; sen = vq[i].s; si = vq[i].i;
      tick();
      chk($sformatf("tbl[%0d].so", i),   so_m,   vq[i].eso);
      chk($sformatf("tbl[%0d].busy", i), busy_m, vq[i].eb);
      chk($sformatf("tbl[%0d].done", i), done_m, vq[i].ed);
      chk($sformatf("tbl[%0d].ovr", i),  ovr_m,  vq[i].eo);
      chk($sformatf("tbl[%0d].cnt", i),  cnt_m,  vq[i].ec);
    end

    // Spaced strobes, both bit orders fed identically.
    em = 8'h96;
    rst_n = 1'b0; load = 1'b0; sen = 1'b0; si = 1'b0;
    tick();
    rst_n = 1'b1; load = 1'b1; d = em;
    tick();
    load = 1'b0; d = '0;
    for (int k = 0; k < W; k++) begin
      chk($sformatf("seq.msb_so[%0d]", k), so_m, em[W-1-k]);
      chk($sformatf("seq.lsb_so[%0d]", k), so_l, em[k]);
      chk($sformatf("seq.cnt[%0d]", k), cnt_l, W - k);
      sen = 1'b1;
      tick();
      sen = 1'b0;
      if (k < W-1) begin
        chk($sformatf("seq.nodone[%0d]", k), {done_m, done_l}, 0);
        tick();
        tick();
      end
    end
    chk("seq.done", {done_m, done_l}, 3);
    chk("seq.busy_fall", {busy_m, busy_l}, 0);
    chk("seq.cnt_end", cnt_m, 0);
    tick();
    chk("seq.done_clear", {done_m, done_l}, 0);

    // Random traffic against the reference.
    for (int c = 0; c < 3000; c++) begin
      rst_n = (c == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
      load  = ($urandom_range(0, 3) == 0);
      sen   = $urandom_range(0, 1);
      si    = $urandom_range(0, 1);
      d     = W'($urandom);
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("rnd[%0d].so_m", c), so_m, ob[0][0]);
      chk($sformatf("rnd[%0d].so_l", c), so_l, ob[1][0]);
      chk($sformatf("rnd[%0d].busy", c), {busy_m, busy_l}, (rem != 0) ? 3 : 0);
      chk($sformatf("rnd[%0d].done", c), {done_m, done_l}, m_done ? 3 : 0);
      chk($sformatf("rnd[%0d].ovr", c),  {ovr_m, ovr_l},   m_ovr ? 3 : 0);
      chk($sformatf("rnd[%0d].cnt_m", c), cnt_m, rem);
      chk($sformatf("rnd[%0d].cnt_l", c), cnt_l, rem);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
